// File: rtl/edge_cache_loader.sv
// Write-side loader for the edge cache: turns a row-major weight stream into
// registered single-cycle cache write strobes addressed {to node, from node}.
module edge_cache_loader #(
    parameter int MAX_NODES   = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int VALUE_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [INDEX_WIDTH:0]     node_count,
    input  logic                     in_valid,
    input  logic [VALUE_WIDTH-1:0]   in_data,
    output logic                     in_ready,
    output logic [2*INDEX_WIDTH-1:0] cache_address,
    output logic                     cache_write_enable,
    output logic [VALUE_WIDTH-1:0]   cache_write_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH:0]   COUNT_ONE = (INDEX_WIDTH+1)'(1);
    localparam logic [INDEX_WIDTH:0]   MAX_COUNT = (INDEX_WIDTH+1)'(MAX_NODES);
    localparam logic [INDEX_WIDTH-1:0] INDEX_ONE = INDEX_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic [INDEX_WIDTH:0]   node_total;
    logic [INDEX_WIDTH:0]   last_index;
    logic [INDEX_WIDTH-1:0] from_idx;
    logic [INDEX_WIDTH-1:0] to_idx;
    logic                   count_legal;
    logic                   start_ok;
    logic                   accept;
    logic                   to_last;
    logic                   from_last;

    assign count_legal = (node_count != '0) && (node_count <= MAX_COUNT);
    assign start_ok    = (state == IDLE) && start && count_legal;
    assign last_index  = node_total - COUNT_ONE;
    assign to_last     = ({1'b0, to_idx} == last_index);
    assign from_last   = ({1'b0, from_idx} == last_index);
    // abort outranks acceptance, so an aborted beat never reaches the cache
    assign accept      = in_valid && (state == LOAD) && !abort;
    assign in_ready    = (state == LOAD);
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && to_last && from_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // to_idx is the inner counter: a full row of destinations per from node
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            node_total         <= '0;
            from_idx           <= '0;
            to_idx             <= '0;
            cache_address      <= '0;
            cache_write_data   <= '0;
            cache_write_enable <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
        end else begin
            cache_write_enable <= accept;
            done               <= accept && to_last && from_last;
            error              <= (state == IDLE) && start && !count_legal;
            if (accept) begin
                cache_address    <= {to_idx, from_idx};
                cache_write_data <= in_data;
            end
            if (start_ok) begin
                node_total <= node_count;
                from_idx   <= '0;
                to_idx     <= '0;
            end else if ((state != IDLE) && abort) begin
                from_idx <= '0;
                to_idx   <= '0;
            end else if (accept) begin
                if (to_last) begin
                    to_idx   <= '0;
                    from_idx <= from_last ? '0 : from_idx + INDEX_ONE;
                end else begin
                    to_idx <= to_idx + INDEX_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_cache_loader.sv
// Scoreboard bench for edge_cache_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every strobe the loader issues.
module tb_edge_cache_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  node_count = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [3:0]  cache_address;
    logic        cache_write_enable;
    logic [15:0] cache_write_data;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [3:0]  address;
        logic [15:0] data;
        logic        done;
    } write_t;

    write_t expected_q[$];
    int compared_count = 0;
    int mismatch_count = 0;
    int done_seen = 0;
    int error_seen = 0;

    int full_rate_addr[9]   = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
    int backpressure_valid[7] = '{1, 0, 0, 1, 1, 0, 1};
    int backpressure_addr[4]  = '{0, 4, 1, 5};
    int abort_addr[3]       = '{0, 4, 8};
    int reset_addr[4]       = '{0, 4, 8, 12};

    edge_cache_loader #(
        .MAX_NODES(4),
        .INDEX_WIDTH(2),
        .VALUE_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .node_count(node_count),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .cache_address(cache_address),
        .cache_write_enable(cache_write_enable),
        .cache_write_data(cache_write_data),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared_count++;
        if (actual !== required) begin
            mismatch_count++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic pushWrite(input logic [3:0] address, input logic [15:0] data, input logic last);
        write_t w;
        w.address = address;
        w.data    = data;
        w.done    = last;
        expected_q.push_back(w);
    endtask

    // Drives one cycle of inputs, then checks the strobe that cycle produced
    task automatic applyStimulus(input logic s, input logic [2:0] n, input logic v,
                                 input logic [15:0] d, input logic a, input logic expect_write);
        start      = s;
        node_count = n;
        in_valid   = v;
        in_data    = d;
        abort      = a;
        @(posedge clock);
        #1;
        checkOutput("strobe_timing", 32'(cache_write_enable), 32'(expect_write));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_write_enable"}, 32'(cache_write_enable), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_address"}, 32'(cache_address), 32'd0);
        checkOutput({tag, "_data"}, 32'(cache_write_data), 32'd0);
    endtask

    initial begin : monitor
        write_t exp_w;
        forever begin
            @(negedge clock);
            if (done) done_seen++;
            if (error) error_seen++;
            if (cache_write_enable) begin
                if (expected_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(cache_write_enable), 32'd0);
                end else begin
                    exp_w = expected_q.pop_front();
                    checkOutput("write", 32'({cache_address, cache_write_data, done}), 32'(exp_w));
                end
            end else if (done) begin
                checkOutput("done_without_write", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            start      = i[0];
            in_valid   = 1'b1;
            in_data    = 16'h1234 + 16'(i);
            node_count = 3'd3;
            @(posedge clock);
            #1;
        end
        checkAllZero("reset");
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        reset_n  = 1'b1;
        @(posedge clock);
        #1;

        // Full-rate load, N=3
        applyStimulus(1'b1, 3'd3, 1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("load_in_ready", 32'(in_ready), 32'd1);
        checkOutput("load_busy", 32'(busy), 32'd1);
        for (int b = 0; b < 9; b++) begin
            pushWrite(4'(full_rate_addr[b]), 16'(b + 1), b == 8);
            applyStimulus(1'b0, 3'd3, 1'b1, 16'(b + 1), 1'b0, 1'b1);
        end
        checkOutput("final_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("done_cycle_busy", 32'(busy), 32'd1);
        checkOutput("done_cycle_done", 32'(done), 32'd1);
        applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Backpressure, N=2
        applyStimulus(1'b1, 3'd2, 1'b0, 16'd0, 1'b0, 1'b0);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 7; c++) begin
                if (backpressure_valid[c] == 1) begin
                    pushWrite(4'(backpressure_addr[k]), 16'h0A00 + 16'(k), k == 3);
                    applyStimulus(1'b0, 3'd2, 1'b1, 16'h0A00 + 16'(k), 1'b0, 1'b1);
                    k++;
                end else begin
                    applyStimulus(1'b0, 3'd2, 1'b0, 16'hDEAD, 1'b0, 1'b0);
                end
            end
        end
        applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);

        // Illegal node counts
        applyStimulus(1'b1, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("error_count0", 32'(error), 32'd1);
        checkOutput("error_count0_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 3'd0, 1'b1, 16'h1111, 1'b0, 1'b0);
        checkOutput("error_count0_pulse", 32'(error), 32'd0);
        applyStimulus(1'b1, 3'd5, 1'b1, 16'h2222, 1'b0, 1'b0);
        checkOutput("error_count5", 32'(error), 32'd1);
        checkOutput("error_count5_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 3'd0, 1'b1, 16'h3333, 1'b0, 1'b0);
        checkOutput("error_count5_pulse", 32'(error), 32'd0);
        checkOutput("error_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);

        // Abort on the 4th beat, then a one-node restart
        applyStimulus(1'b1, 3'd4, 1'b0, 16'd0, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            pushWrite(4'(abort_addr[b]), 16'h0B00 + 16'(b), 1'b0);
            applyStimulus(1'b0, 3'd4, 1'b1, 16'h0B00 + 16'(b), 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 3'd4, 1'b1, 16'h0B03, 1'b1, 1'b0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 3'd4, 1'b1, 16'h0B04, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b0, 16'd0, 1'b0, 1'b0);
        pushWrite(4'd0, 16'hBEEF, 1'b1);
        applyStimulus(1'b0, 3'd1, 1'b1, 16'hBEEF, 1'b0, 1'b1);
        checkOutput("restart_done", 32'(done), 32'd1);
        applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);

        // Reset mid-load after 5 beats; the 5th strobe is wiped before it lands
        applyStimulus(1'b1, 3'd4, 1'b0, 16'd0, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) begin
            if (b < 4) pushWrite(4'(reset_addr[b]), 16'h0C00 + 16'(b), 1'b0);
            applyStimulus(1'b0, 3'd4, 1'b1, 16'h0C00 + 16'(b), 1'b0, 1'b1);
        end
        reset_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 3'd4, 1'b1, 16'h0D00 + 16'(c), 1'b0, 1'b0);
        end
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0);

        checkOutput("queue_drained", 32'(expected_q.size()), 32'd0);
        checkOutput("done_pulses", 32'(done_seen), 32'd3);
        checkOutput("error_pulses", 32'(error_seen), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/edge_cache_loader.md
# edge_cache_loader

Write-side front end for the edge cache block RAM. It accepts a row-major stream of edge weights for an N-node graph over a valid/ready handshake. It converts each accepted beat into a registered single-cycle write strobe on the cache's address/write-data port, packing the address as {to node, from node}. It tracks the load with counters, skips addresses outside the active N×N region, and reports completion or error to the Dijkstra controller.

## Interface

**Parameters**
- MAX_NODES, `DEFAULT_MAX_NODES`: capacity of the cache, in nodes per side.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH`: width of one node index. Requires 2**INDEX_WIDTH ≥ MAX_NODES.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH`: width of an edge weight.

**Ports**
- clock, in, 1: single clock. All logic is rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a load. Honoured only in IDLE.
- abort, in, 1: cancel the load in progress.
- node_count, in, INDEX_WIDTH+1: N, the number of active nodes. Sampled when start is accepted.
- in_valid, in, 1: a stream beat is present.
- in_data, in, VALUE_WIDTH: the edge weight for the current beat.
- in_ready, out, 1: the loader can accept a beat.
- cache_address, out, 2*INDEX_WIDTH: write address to the cache. Bits [2W-1:W] hold the to node and bits [W-1:0] hold the from node, where W = INDEX_WIDTH.
- cache_write_enable, out, 1: write strobe to the cache.
- cache_write_data, out, VALUE_WIDTH: write data to the cache.
- busy, out, 1: high in LOAD and in DONE.
- done, out, 1: one-cycle pulse marking a complete load.
- error, out, 1: one-cycle pulse when start carries an illegal node_count.

## Operation

**States:** IDLE, LOAD, DONE.

**Reset**
- State returns to IDLE.
- Both counters are cleared.
- Every output goes to 0, including in_ready, cache_address and cache_write_data.

**IDLE**
- When start=1 and 1 ≤ node_count ≤ MAX_NODES:
  - Latch N.
  - Set from_idx=0 and to_idx=0.
  - Go to LOAD.
- When start=1 with node_count=0 or node_count > MAX_NODES:
  - error=1 in the next cycle.
  - Stay in IDLE. No writes are issued.

**LOAD**
- in_ready=1, driven combinationally from the state.
- A beat is accepted when in_valid and in_ready are both high. The following happens on that clock edge:
  - cache_address ← {to_idx, from_idx}, cache_write_data ← in_data, cache_write_enable ← 1.
  - Counter advance: to_idx is the inner counter. When to_idx reaches N-1 it wraps to 0 and from_idx increments.
  - When the accepted beat is from_idx=N-1 and to_idx=N-1, go to DONE.
- When no beat is accepted, cache_write_enable ← 0 and the address and data registers hold their values.
- Stream order is all destinations of from node 0, then all destinations of from node 1, and so on: N² beats in total.
- Addresses whose to or from index is ≥ N are never written.
- start is ignored in LOAD.

**DONE**
- Lasts exactly one cycle.
- The final write strobe is issued in this cycle, and done=1 at the same time.
- in_ready=0.
- The next state is IDLE.

**abort**
- abort=1 in LOAD or DONE forces the next state to IDLE and clears the counters.
- A strobe registered on that edge is suppressed, so cache_write_enable=0 in the following cycle.
- done is not asserted.
- abort is ignored in IDLE.

**Simultaneous events**
- abort takes priority over beat acceptance and over the LOAD→DONE transition.
- start is ignored in the DONE cycle.

## Timing

- Write latency: a beat accepted on clock edge k produces cache_write_enable=1 for exactly the cycle after edge k, with the corresponding address and data. The cache captures the write on edge k+1.
- Throughput: one beat per cycle when in_valid is held high.
- Load duration: a gap-free load of N² beats occupies LOAD for N² cycles, followed by 1 DONE cycle.
- in_ready falls in the cycle after the last beat is accepted.
- done and error are registered single-cycle pulses.
- reset_n=0 mid-load clears all outputs immediately, without waiting for a clock edge. No write strobe follows after release.

## Test plan

Configuration for all scenarios: MAX_NODES=4, INDEX_WIDTH=2, VALUE_WIDTH=16.

1. **Reset:** hold reset_n=0 while toggling inputs. Required: in_ready, cache_write_enable, done, error and busy are all 0; cache_address=0 and cache_write_data=0.
2. **Full-rate load:** start with N=3, then drive in_valid=1 with data 1..9 on consecutive cycles. Required:
   - Writes (data→address): 1→0, 2→4, 3→8, 4→1, 5→5, 6→9, 7→2, 8→6, 9→10.
   - done pulses in the cycle of the write to address 10.
   - Addresses 3, 7 and 11–15 are never written.
3. **Backpressure:** N=2 with in_valid toggling 1,0,0,1,1,0,1. Required:
   - Exactly 4 strobes, at addresses 0, 4, 1, 5, in order, each one cycle after its accepted beat.
   - No strobe is issued in gap cycles.
4. **Illegal count:** start with node_count=0, then start with node_count=5. Required:
   - error=1 for one cycle after each start.
   - in_ready stays 0 and there are no writes.
5. **Abort and restart:** N=4, abort asserted together with the 4th beat. Required:
   - Only 3 strobes, at addresses 0, 4 and 8.
   - in_ready=0 on the next cycle, and done is never asserted.
   - A subsequent start with N=1 and one beat of 0xBEEF writes 0xBEEF to address 0 with done in the same cycle.
6. **Reset mid-load:** reset_n=0 after 5 beats of an N=4 load. Required:
   - All outputs are 0 asynchronously.
   - After release the loader is in IDLE with in_ready=0, and no further strobes are issued.
